// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the Knight's Tour command sequence player.
package cmd_seq_pkg;

  // Player FSM states
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SENT,
    WAIT_RESP,
    NEXT,
    DONE,
    ERR
  } state_t;

  // Reason reported on err_code
  typedef enum logic [1:0] {
    E_NONE,
    E_NAK,
    E_TIMEOUT,
    E_ABORT
  } err_code_t;

  // Tour opcodes (top nibble of a command)
  localparam logic [3:0] CMD_OP_START_CAL = 4'h2;
  localparam logic [3:0] CMD_OP_MOVE      = 4'h4;

  // Move headings (middle byte of a move command)
  localparam logic [7:0] HEAD_NORTH = 8'h00;
  localparam logic [7:0] HEAD_WEST  = 8'h3F;
  localparam logic [7:0] HEAD_SOUTH = 8'h7F;
  localparam logic [7:0] HEAD_EAST  = 8'hBF;

  // Positive response from RemoteComm
  localparam logic [7:0] DEFAULT_ACK = 8'hA5;

  // Build a move command from a heading and a square count
  function automatic logic [15:0] mk_move(input logic [7:0] heading, input logic [3:0] sqrs);
    return {CMD_OP_MOVE, heading, sqrs};
  endfunction

endpackage

// File: rtl/cmd_seq_player_if.sv
// RemoteComm link between the sequence player (master) and RemoteComm (slave).
// Handshake: the master holds cmd stable and pulses send_cmd for one cycle;
// the slave answers with a one-cycle cmd_sent when transmission is finished,
// then a one-cycle resp_rdy with resp valid in that same cycle. There is no
// back-pressure: a resp_rdy the master is not waiting for is dropped.
interface cmd_seq_player_if #(
  parameter int CMD_W  = 16,
  parameter int RESP_W = 8
);
  logic [CMD_W-1:0]  cmd;
  logic              send_cmd;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;

  modport master (output cmd, output send_cmd, input cmd_sent, input resp_rdy, input resp);
  modport slave  (input cmd, input send_cmd, output cmd_sent, output resp_rdy, output resp);
endinterface

// File: rtl/cmd_seq_mem.sv
// Command slot storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module cmd_seq_mem #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [CMD_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [CMD_W-1:0] rdata_o
);
  logic [CMD_W-1:0] mem_q [DEPTH];

  // Write one slot per cycle when enabled
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cmd_seq_player.sv
// Plays a programmed list of tour commands through RemoteComm, checking each
// response against ACK, with repeat passes, response timeout and abort.
module cmd_seq_player
  import cmd_seq_pkg::*;
#(
  parameter int                DEPTH   = 16,
  parameter int                CMD_W   = 16,
  parameter int                RESP_W  = 8,
  parameter logic [RESP_W-1:0] ACK     = DEFAULT_ACK,
  parameter int                LOOP_W  = 4,
  parameter int                TO_W    = 24,
  parameter logic [TO_W-1:0]   TIMEOUT = 24'hFF_FFFF,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CMD_W-1:0]  wr_data,
  input  logic [LW-1:0]     seq_len,
  input  logic [LOOP_W-1:0] loops,
  input  logic              start,
  input  logic              abort,
  cmd_seq_player_if.master  rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [AW-1:0]     cur_idx,
  output logic [LOOP_W-1:0] loop_cnt,
  output state_t            state_dbg
);

  state_t            state_q;
  err_code_t         err_code_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              send_q;
  logic              done_q;
  logic              err_q;
  logic [AW-1:0]     idx_q;
  logic [LOOP_W-1:0] loop_q;
  logic [LOOP_W-1:0] loops_q;
  logic [LW-1:0]     len_q;
  logic [TO_W-1:0]   to_q;

  logic [AW-1:0]     rd_addr;
  logic [CMD_W-1:0]  rd_data;
  logic              last_slot;
  logic              more_loops;
  logic [LOOP_W:0]   loop_next_ext;
  logic [TO_W-1:0]   to_next;
  logic              to_hit;
  logic              resp_ok;

  // Writes are only accepted while idle so a running sequence cannot change
  cmd_seq_mem #(.DEPTH(DEPTH), .CMD_W(CMD_W)) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en && (state_q == IDLE)),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Sequencing helpers; rd_addr points at the slot the next ISSUE will load
  always_comb begin
    last_slot     = (LW'(idx_q) + LW'(1)) >= len_q;
    loop_next_ext = {1'b0, loop_q} + (LOOP_W + 1)'(1);
    more_loops    = (loops_q == '0) || (loop_next_ext < {1'b0, loops_q});
    rd_addr       = ((state_q == NEXT) && !last_slot) ? idx_q + AW'(1) : '0;
    to_next       = to_q + TO_W'(1);
    to_hit        = (TIMEOUT != '0) && (to_next == TIMEOUT);
    resp_ok       = (rc.resp == ACK);
  end

  // Player FSM; err/err_code are registered on the edge that detects the
  // failure so err rises exactly when the fault is seen, ERR then drops busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_code_q <= E_NONE;
      cmd_q      <= '0;
      send_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      loop_q     <= '0;
      loops_q    <= '0;
      len_q      <= '0;
      to_q       <= '0;
    end else begin
      send_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q    <= IDLE;
        err_q      <= 1'b1;
        err_code_q <= E_ABORT;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= E_NONE;
              idx_q      <= '0;
              loop_q     <= '0;
              len_q      <= seq_len;
              loops_q    <= loops;
              if (seq_len == '0) begin
                done_q <= 1'b1;
              end else if (seq_len > LW'(DEPTH)) begin
                done_q     <= 1'b1;
                err_q      <= 1'b1;
                err_code_q <= E_NAK;
              end else begin
                state_q <= ISSUE;
                cmd_q   <= rd_data;
                send_q  <= 1'b1;
              end
            end
          end
          ISSUE: state_q <= WAIT_SENT;
          WAIT_SENT: begin
            if (rc.cmd_sent) begin
              to_q <= '0;
              if (rc.resp_rdy && resp_ok) begin
                state_q <= NEXT;
              end else if (rc.resp_rdy) begin
                state_q    <= ERR;
                err_q      <= 1'b1;
                err_code_q <= E_NAK;
              end else begin
                state_q <= WAIT_RESP;
              end
            end
          end
          WAIT_RESP: begin
            to_q <= to_next;
            if (rc.resp_rdy && resp_ok) begin
              state_q <= NEXT;
            end else if (rc.resp_rdy) begin
              state_q    <= ERR;
              err_q      <= 1'b1;
              err_code_q <= E_NAK;
            end else if (to_hit) begin
              state_q    <= ERR;
              err_q      <= 1'b1;
              err_code_q <= E_TIMEOUT;
            end
          end
          NEXT: begin
            if (!last_slot) begin
              idx_q   <= idx_q + AW'(1);
              state_q <= ISSUE;
              cmd_q   <= rd_data;
              send_q  <= 1'b1;
            end else begin
              loop_q <= loop_q + LOOP_W'(1);
              if (more_loops) begin
                idx_q   <= '0;
                state_q <= ISSUE;
                cmd_q   <= rd_data;
                send_q  <= 1'b1;
              end else begin
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          ERR:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rc.cmd      = cmd_q;
  assign rc.send_cmd = send_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cur_idx     = idx_q;
  assign loop_cnt    = loop_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cmd_seq_player.sv
// Directed bench for cmd_seq_player: a RemoteComm responder model, an
// expected-command scoreboard popped on every send_cmd, and status checks.
module tb_cmd_seq_player;
  import cmd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [4:0]  seq_len = '0;
  logic [3:0]  loops = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [3:0]  cur_idx, loop_cnt;
  state_t      state_dbg;

  cmd_seq_player_if #(.CMD_W(16), .RESP_W(8)) rc ();

  cmd_seq_player #(.TIMEOUT(24'd100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seq_len   (seq_len),
    .loops     (loops),
    .start     (start),
    .abort     (abort),
    .rc        (rc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cur_idx   (cur_idx),
    .loop_cnt  (loop_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int send_cnt = 0;
  int rsp_count = 0;
  int nak_at = -1;
  int rsp_delay = 9;
  logic [15:0] exp_q[$];
  logic [15:0] fig8 [8] = '{16'h47F2, 16'h4BF1, 16'h4002, 16'h43F1,
                            16'h4002, 16'h4BF1, 16'h47F2, 16'h43F1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp_v);
    end
  endtask

  // Driver tasks
  task automatic load(input int a, input logic [15:0] d);
    wr_addr = a[3:0];
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic kick(input int len, input int lps);
    seq_len = len[4:0];
    loops = lps[3:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s still busy after %0d cycles", name, budget);
    end
  endtask

  // RemoteComm responder: cmd_sent 2 cycles after send_cmd, response after rsp_delay more
  initial begin
    rc.cmd_sent = 1'b0;
    rc.resp_rdy = 1'b0;
    rc.resp = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rc.send_cmd) begin
        repeat (2) @(negedge clk);
        rc.cmd_sent = 1'b1;
        @(negedge clk);
        rc.cmd_sent = 1'b0;
        rsp_count++;
        repeat (rsp_delay) @(negedge clk);
        rc.resp = (rsp_count == nak_at) ? 8'h5A : 8'hA5;
        rc.resp_rdy = 1'b1;
        @(negedge clk);
        rc.resp_rdy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every send_cmd pulse must match the head of exp_q
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rc.send_cmd) begin
        send_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send got=%0h want=none", rc.cmd);
        end else begin
          e = exp_q.pop_front();
          chk("send_cmd_value", 32'(rc.cmd), 32'(e));
        end
      end
    end
  end

  initial begin : main
    int n;
    int base;
    int t_sent;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(rc.cmd), 0);
    chk("rst_send", 32'(rc.send_cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_idx", 32'(cur_idx), 0);
    chk("rst_loop", 32'(loop_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Figure-8: 8 moves, one pass
    for (int i = 0; i < 8; i++) load(i, fig8[i]);
    base = send_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(fig8[i]);
    kick(8, 1);
    chk("start_latency", 32'(rc.send_cmd), 1);
    wait_idle("fig8", 1000);
    chk("fig8_done", 32'(done), 1);
    chk("fig8_err", 32'(err), 0);
    chk("fig8_loop", 32'(loop_cnt), 1);
    chk("fig8_idx", 32'(cur_idx), 7);
    chk("fig8_sends", send_cnt - base, 8);
    chk("fig8_queue", exp_q.size(), 0);

    // Repeat: 2 slots x 3 passes
    base = send_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back(i % 2 == 0 ? 16'h47F2 : 16'h4BF1);
    kick(2, 3);
    wait_idle("repeat", 1000);
    chk("rep_done", 32'(done), 1);
    chk("rep_loop", 32'(loop_cnt), 3);
    chk("rep_idx", 32'(cur_idx), 1);
    chk("rep_sends", send_cnt - base, 6);

    // Run forever, abort in WAIT_RESP after 10 passes (first cmd of pass 11 already out)
    base = send_cnt;
    for (int i = 0; i < 21; i++) exp_q.push_back(i % 2 == 0 ? 16'h47F2 : 16'h4BF1);
    kick(2, 0);
    n = 0;
    while (loop_cnt != 4'd10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("forever_passes", 32'(loop_cnt), 10);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(err), 1);
    chk("abort_code", 32'(err_code), 3);
    repeat (40) @(negedge clk);
    chk("abort_sends", send_cnt - base, 21);
    chk("abort_queue", exp_q.size(), 0);
    chk("abort_done", 32'(done), 0);

    // NAK on the third response
    base = send_cnt;
    nak_at = rsp_count + 3;
    for (int i = 0; i < 3; i++) exp_q.push_back(fig8[i]);
    kick(8, 1);
    n = 0;
    while (err !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("nak_err", 32'(err), 1);
    chk("nak_busy_err_cycle", 32'(busy), 1);
    @(negedge clk);
    chk("nak_busy_after", 32'(busy), 0);
    chk("nak_code", 32'(err_code), 1);
    chk("nak_idx", 32'(cur_idx), 2);
    repeat (30) @(negedge clk);
    chk("nak_sends", send_cnt - base, 3);
    nak_at = -1;

    // Timeout: responder answers far too late
    rsp_delay = 150;
    exp_q.push_back(16'h47F2);
    kick(1, 1);
    n = 0;
    while (rc.cmd_sent !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    t_sent = cyc + 1;  // edge on which the DUT captures cmd_sent
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", cyc - t_sent, 100);
    chk("timeout_code", 32'(err_code), 2);
    wait_idle("timeout", 10);
    repeat (200) @(negedge clk);
    chk("late_resp_err", 32'(err), 1);
    chk("late_resp_code", 32'(err_code), 2);
    chk("late_resp_done", 32'(done), 0);
    chk("late_resp_busy", 32'(busy), 0);
    rsp_delay = 9;

    // Boundaries: empty and oversized sequence
    base = send_cnt;
    kick(0, 1);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_err", 32'(err), 0);
    kick(17, 1);
    chk("len17_done", 32'(done), 1);
    chk("len17_err", 32'(err), 1);
    chk("len17_code", 32'(err_code), 1);
    repeat (5) @(negedge clk);
    chk("len_bad_sends", send_cnt - base, 0);

    // Write and start while busy are ignored
    base = send_cnt;
    exp_q.push_back(16'h47F2);
    kick(1, 1);
    load(0, 16'h1234);
    kick(2, 1);
    wait_idle("busy_ignore", 200);
    chk("busy_sends", send_cnt - base, 1);
    chk("busy_loop", 32'(loop_cnt), 1);
    exp_q.push_back(16'h47F2);
    kick(1, 1);
    wait_idle("slot_kept", 200);
    chk("slot_kept_queue", exp_q.size(), 0);

    // Asynchronous reset in WAIT_RESP, then replay from slot 0
    exp_q.push_back(16'h47F2);
    kick(8, 1);
    n = 0;
    while (state_dbg != WAIT_RESP && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_resp", 32'(state_dbg), 32'(WAIT_RESP));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd", 32'(rc.cmd), 0);
    chk("arst_send", 32'(rc.send_cmd), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(cur_idx), 0);
    chk("arst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    base = send_cnt;
    exp_q.push_back(16'h47F2);
    exp_q.push_back(16'h4BF1);
    kick(2, 1);
    wait_idle("replay", 200);
    chk("replay_done", 32'(done), 1);
    chk("replay_sends", send_cnt - base, 2);
    chk("replay_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_seq_player.md
Name: cmd_seq_player

Overview:
Hardware move-sequence player for the Knight's Tour bench and demo builds. It holds a programmable list of 16-bit tour commands, such as the calibrate/move opcodes 0x2xxx and 0x4xxx. It issues each command through the RemoteComm send_cmd/cmd_sent handshake, then waits for the 8-bit response and checks it against the ACK value. It supports repeat loops, response timeout and abort. It sits between a host/config source and RemoteComm, replacing hand-written per-tour stimulus sequences.

Parameters:
DEPTH, 16, number of command slots.
CMD_W, 16, command width.
RESP_W, 8, response width.
ACK, 8'hA5, expected positive response.
LOOP_W, 4, width of the repeat count; 0 means run forever.
TO_W, 24, width of the timeout counter.
TIMEOUT, 24'hFF_FFFF, cycles allowed in WAIT_RESP before error; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one command slot; ignored while busy
wr_addr  in  $clog2(DEPTH)  slot index
wr_data  in  CMD_W  command value
seq_len  in  $clog2(DEPTH+1)  number of slots to play, sampled at start
loops  in  LOOP_W  pass count, sampled at start
start  in  1  begin playback; ignored while busy
abort  in  1  stop playback
cmd  out  CMD_W  command presented to RemoteComm
send_cmd  out  1  one-cycle launch pulse
cmd_sent  in  1  RemoteComm finished transmitting
resp_rdy  in  1  response byte valid, one-cycle pulse
resp  in  RESP_W  response byte
busy  out  1  playback in progress
done  out  1  sticky; set on normal completion
err  out  1  sticky; set on NAK or timeout
err_code  out  2  0 none, 1 NAK, 2 TIMEOUT, 3 ABORT
cur_idx  out  $clog2(DEPTH)  slot currently or last issued
loop_cnt  out  LOOP_W  completed passes

Behaviour:
- Reset values: cmd=0, send_cmd=0, busy=0, done=0, err=0, err_code=0, cur_idx=0, loop_cnt=0, state IDLE, timeout counter 0. Memory contents are not reset.
- IDLE. On start with abort=0:
  - clear done, err, err_code, cur_idx and loop_cnt; latch seq_len and loops.
  - if seq_len==0, or seq_len>DEPTH: set done next cycle (seq_len>DEPTH additionally sets err_code=1 and err), and stay in IDLE.
  - otherwise go to ISSUE.
- ISSUE (1 cycle): cmd <= mem[cur_idx]; send_cmd asserted for exactly this cycle; then go to WAIT_SENT. cmd holds its value until the next ISSUE.
- WAIT_SENT: wait for cmd_sent, then clear the timeout counter and go to WAIT_RESP. A resp_rdy arriving in the same cycle as cmd_sent is accepted as the response.
- WAIT_RESP: the timeout counter increments each cycle.
  - resp_rdy with resp==ACK: go to NEXT.
  - resp_rdy with any other value: go to ERR with code 1.
  - counter reaches TIMEOUT (when TIMEOUT != 0): go to ERR with code 2; err is asserted on the TIMEOUT-th cycle after entry.
- NEXT (1 cycle):
  - if cur_idx < seq_len-1: cur_idx++ and go to ISSUE.
  - else: loop_cnt++ (wraps at 2^LOOP_W); if loops==0 or loop_cnt+1 < loops, set cur_idx=0 and go to ISSUE; otherwise go to DONE.
- DONE: set done, return to IDLE. ERR: set err and err_code, return to IDLE. cur_idx keeps the failing slot.
- resp_rdy outside WAIT_RESP is ignored.
- abort, in any non-IDLE state, returns to IDLE on the next edge with err=1 and err_code=3, and no further send_cmd is issued. abort together with start in IDLE means start is ignored.
- busy=1 in every state except IDLE.
- An asynchronous reset mid-operation returns to IDLE immediately and drops send_cmd within the same cycle.
- Latency from start to the first send_cmd is exactly 1 cycle.

Decomposition:
- Package cmd_seq_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, NEXT, DONE, ERR};
  - err_code enum {E_NONE, E_NAK, E_TIMEOUT, E_ABORT};
  - tour opcode constants: CMD_OP_START_CAL, CMD_OP_MOVE=4'h4, heading constants 8'h00/3F/7F/BF;
  - default ACK 8'hA5.
- Sub-module cmd_seq_mem: DEPTH x CMD_W register file with one synchronous write port and an asynchronous read port.
- The FSM, loop counter and timeout counter stay in the top module.

Test Plan:
- Figure-8 load: 8 slots 47F2, 4BF1, 4002, 43F1, 4002, 4BF1, 47F2, 43F1; seq_len=8; loops=1; the responder returns A5 10 cycles after each cmd_sent -> exactly 8 send_cmd pulses with cmd in that order, then done=1, loop_cnt=1, err=0.
- Repeat: seq_len=2 (47F2, 4BF1), loops=3 -> issue order 47F2, 4BF1, 47F2, 4BF1, 47F2, 4BF1, then done with loop_cnt=3. With loops=0, after 10 passes abort -> err_code=3 and no further send_cmd.
- NAK: the third response is 8'h5A -> err=1, err_code=1, cur_idx=2, no fourth send_cmd, busy=0 one cycle later.
- Timeout: TIMEOUT=100 and the responder stays silent -> err rises exactly 100 cycles after cmd_sent, err_code=2. A late resp_rdy afterwards is ignored.
- Boundaries: start with seq_len=0 -> done the next cycle with no send_cmd. wr_en while busy leaves the slot unchanged. start while busy is ignored.
- Reset: assert rst_n=0 while in WAIT_RESP -> all outputs return to their reset values asynchronously; start after release replays from slot 0.
